keypad_scan: RTL
================

# keypad_scan

4x4 matrix keypad scanner for the lab board front panel. It sits beside the 8x8 dot-matrix display driver and shares its 1 kHz scan clock. It drives one keypad row low at a time and samples the four column lines. Each press is debounced and reported as a 4-bit key code with a one-cycle valid strobe and a held level, for the control logic that selects what the matrix shows.

## Interface
- DEBOUNCE_CYC, 20: consecutive identical samples required to accept a press or a release (20 ms at 1 kHz); legal range 1..65535.
- REPEAT_DELAY, 500: cycles from first key_valid to first repeat; used only with KEYPAD_REPEAT_EN.
- REPEAT_RATE, 100: cycles between subsequent repeats; used only with KEYPAD_REPEAT_EN.
- clk  in  1  scan clock, 1 kHz nominal, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- col_in  in  4  keypad columns, active-low (pulled up externally); bit c = column c; synchronised externally.
- row_out  out  4  keypad row drive, active-low one-hot; bit r = row r.
- key_code  out  4  last accepted key, row*4 + col.
- key_valid  out  1  one-cycle strobe: key_code newly accepted (or repeated).
- key_down  out  1  high from acceptance until debounced release.

## Operation
- Reset values (async, immediate):
  - row_out=4'b1110
  - key_code=0
  - key_valid=0
  - key_down=0
  - state=SCAN
  - row index=0
  - all counters=0
- States are SCAN, DEBOUNCE, PRESSED and RELEASE.
- SCAN:
  - row_out drives row index r low.
  - Each edge samples col_in against r.
  - If col_in==4'b1111, r advances (3 wraps to 0) and row_out updates on the same edge.
  - Otherwise, latch r and col = lowest-numbered low bit (column 0 has priority), set counter=1, go to DEBOUNCE, and keep row_out on r.
- DEBOUNCE:
  - Each edge samples the latched column bit.
  - If low: counter+1. When counter reaches DEBOUNCE_CYC, set key_code, pulse key_valid, set key_down=1, go to PRESSED.
  - If high: counter=0, go to SCAN with r advanced to the next row.
  - With DEBOUNCE_CYC=1, acceptance happens on the detecting edge itself: SCAN goes straight to PRESSED.
- PRESSED:
  - row_out stays on the latched row.
  - Latched column bit high: counter=1, go to RELEASE.
  - Other columns and rows are ignored, so a second key held concurrently is never reported.
- RELEASE:
  - Latched bit high: counter+1. At DEBOUNCE_CYC, key_down=0, counter=0, go to SCAN at the next row.
  - Latched bit low (bounce): return to PRESSED with no new key_valid and key_down still 1.
- key_code holds its value after release until the next acceptance.
- Counters are 16 bits wide and saturate; they never wrap.

## Timing
- row_out is registered. Row r is driven for at least one full cycle before its sample edge.
- Idle full scan period is 4 cycles.
- Press latency: key_valid is high in the cycle after the edge that takes the DEBOUNCE_CYC-th consecutive low sample, counting the detecting sample as sample 1.
- key_valid is exactly one cycle wide and is never asserted twice for one press (unless repeat is enabled).
- Release latency: key_down falls in the cycle after the DEBOUNCE_CYC-th consecutive high sample.
- Reset asserted mid-press drops key_down and key_valid immediately. Scanning restarts from row 0 after deassertion.
- A key still held after reset is re-detected and re-debounced as a new press.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - In PRESSED, a repeat counter starts at acceptance.
  - key_valid pulses again (same key_code) REPEAT_DELAY cycles after the first strobe, then every REPEAT_RATE cycles.
  - The repeat counter pauses during RELEASE bounce and resumes on return to PRESSED.
  - The repeat counter clears on leaving PRESSED through a completed release.
- KEYPAD_REPEAT_EN undefined:
  - Exactly one key_valid per press.
  - No repeat counter logic is present.

## Test plan
- Reset then idle (col_in=4'hF) for 12 cycles -> row_out cycles 1110,1101,1011,0111,1110..., key_valid never 1, key_down=0.
- DEBOUNCE_CYC=4, hold row 2 col 1 low -> key_valid one cycle with key_code=9, key_down=1 from that cycle on, row_out frozen at 4'b1011.
- DEBOUNCE_CYC=4, press glitch of 2 cycles on row 0 col 3 -> no key_valid, scan resumes at row 1.
- Key 5 accepted, then release with 2-cycle bounce back low, then stable high -> key_down stays 1 through the bounce, falls exactly 4 cycles after the last high-going transition, no second key_valid.
- Row 1 cols 0 and 2 pressed together -> key_code=4. While key 4 is held, row 3 col 3 is pressed -> ignored, key_code stays 4.
- KEYPAD_REPEAT_EN, REPEAT_DELAY=10, REPEAT_RATE=3, key 15 held 20 cycles past acceptance -> key_valid at +0, +10, +13, +16, +19; rst pulsed at +21 -> all outputs 0 at once, row_out=4'b1110.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks an active-low row strobe, debounces a single
// press/release on the latched row/column, and reports a 4-bit key code with a
// one-cycle valid strobe plus a held key_down level.
// Optional auto-repeat of key_valid while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan #(
  parameter int unsigned DEBOUNCE_CYC = 20,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] DEB_TGT = CNT_W'(DEBOUNCE_CYC);
  // A single accepted sample means detection and acceptance coincide.
  localparam bit DEB_ONE = (DEBOUNCE_CYC <= 1);

  // Reject configurations the 16-bit counters cannot represent.
  if (DEBOUNCE_CYC < 1 || DEBOUNCE_CYC > 65535 ||
      REPEAT_DELAY > 65535 || REPEAT_RATE > 65535) begin : g_bad_cfg
    $error("keypad_scan: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       row_q, row_d;
  logic [1:0]       col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       row_out_q, row_out_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_down_q, key_down_d;

  logic             col_bit;
  logic [1:0]       det_col;
  logic [CNT_W-1:0] cnt_inc;

`ifdef KEYPAD_REPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_TGT = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RATE_TGT  = CNT_W'(REPEAT_RATE);

  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_arm_q, rep_arm_d;
  logic [CNT_W-1:0] rep_inc;
  logic [CNT_W-1:0] rep_tgt;
`endif

  // Active-low one-hot row strobe for row index r.
  function automatic logic [3:0] row_drive(input logic [1:0] r);
    return ~(4'b0001 << r);
  endfunction

  // Lowest-numbered low column wins when several are pressed together.
  function automatic logic [1:0] first_low(input logic [3:0] c);
    if (!c[0])      return 2'd0;
    else if (!c[1]) return 2'd1;
    else if (!c[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  // Shared datapath terms: latched column sample, detected column, saturating count.
  always_comb begin
    col_bit = col_in[col_q];
    det_col = first_low(col_in);
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  end

`ifdef KEYPAD_REPEAT_EN
  // Repeat timing: first interval is the initial delay, later ones the rate.
  always_comb begin
    rep_inc = (rep_cnt_q == CNT_MAX) ? rep_cnt_q : rep_cnt_q + CNT_W'(1);
    rep_tgt = rep_arm_q ? RATE_TGT : DELAY_TGT;
  end
`endif

  // Next-state and registered-output logic for the scan/debounce FSM.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    cnt_d       = cnt_q;
    row_out_d   = row_out_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    rep_arm_d   = rep_arm_q;
`endif

    case (state_q)
      ST_SCAN: begin
        if (col_in == 4'hF) begin
          row_d     = row_q + 2'd1;
          row_out_d = row_drive(row_q + 2'd1);
        end else begin
          col_d = det_col;
          if (DEB_ONE) begin
            state_d     = ST_PRESSED;
            cnt_d       = '0;
            key_code_d  = {row_q, det_col};
            key_valid_d = 1'b1;
            key_down_d  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_d   = '0;
            rep_arm_d   = 1'b0;
`endif
          end else begin
            state_d = ST_DEBOUNCE;
            cnt_d   = CNT_W'(1);
          end
        end
      end

      ST_DEBOUNCE: begin
        if (!col_bit) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DEB_TGT) begin
            state_d     = ST_PRESSED;
            cnt_d       = '0;
            key_code_d  = {row_q, col_q};
            key_valid_d = 1'b1;
            key_down_d  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_d   = '0;
            rep_arm_d   = 1'b0;
`endif
          end
        end else begin
          // Bounce before acceptance: give up and resume scanning at the next row.
          state_d   = ST_SCAN;
          cnt_d     = '0;
          row_d     = row_q + 2'd1;
          row_out_d = row_drive(row_q + 2'd1);
        end
      end

      ST_PRESSED: begin
        if (col_bit) begin
          if (DEB_ONE) begin
            state_d    = ST_SCAN;
            cnt_d      = '0;
            key_down_d = 1'b0;
            row_d      = row_q + 2'd1;
            row_out_d  = row_drive(row_q + 2'd1);
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_d  = '0;
            rep_arm_d  = 1'b0;
`endif
          end else begin
            state_d = ST_RELEASE;
            cnt_d   = CNT_W'(1);
          end
        end else begin
`ifdef KEYPAD_REPEAT_EN
          if (rep_inc == rep_tgt) begin
            key_valid_d = 1'b1;
            rep_cnt_d   = '0;
            rep_arm_d   = 1'b1;
          end else begin
            rep_cnt_d = rep_inc;
          end
`endif
        end
      end

      ST_RELEASE: begin
        if (col_bit) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DEB_TGT) begin
            state_d    = ST_SCAN;
            cnt_d      = '0;
            key_down_d = 1'b0;
            row_d      = row_q + 2'd1;
            row_out_d  = row_drive(row_q + 2'd1);
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_d  = '0;
            rep_arm_d  = 1'b0;
`endif
          end
        end else begin
          // Release bounce: key is still down, no new strobe.
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_SCAN;
      end
    endcase
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      row_q       <= 2'd0;
      col_q       <= 2'd0;
      cnt_q       <= '0;
      row_out_q   <= 4'b1110;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      row_out_q   <= row_out_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  // Repeat counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt_q <= '0;
      rep_arm_q <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_arm_q <= rep_arm_d;
    end
  end
`endif

  assign row_out   = row_out_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule
